// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the parametrised hazard / forwarding unit.
package pipe_hazard_pkg;

    // Register indices are stored at a fixed width so the entry struct can live
    // in the package; the unit zero-extends its REG_W-wide ports into it.
    // NUM_REGS up to 2**MAX_REG_W is supported.
    localparam int unsigned MAX_REG_W = 8;

    // Operand select value meaning "take the register file output".
    localparam int unsigned SEL_REGFILE = 0;

    // One tracked in-flight instruction. Only the EXE entry reads its src fields.
    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 is_load;
        logic [MAX_REG_W-1:0] dest;
        logic [MAX_REG_W-1:0] src_1;
        logic [MAX_REG_W-1:0] src_2;
        logic                 src1_used;
        logic                 src2_used;
    } track_entry_t;

    // Empty slot injected on stalls, flushes and reset.
    localparam track_entry_t TRACK_BUBBLE = '0;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source register against every tracked stage and reports the
// qualified matches plus the youngest (lowest-index) matching stage.
module hazard_src_match
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SEL_W = 2
) (
    input  logic [DEPTH-1:0]                producer_vec, // valid & wb_en per stage
    input  logic [DEPTH-1:0][MAX_REG_W-1:0] dest_vec,
    input  logic [MAX_REG_W-1:0]            src,
    input  logic                            src_used,
    input  logic [DEPTH-1:0]                stage_mask,   // stages eligible for this query
    output logic [DEPTH-1:0]                match_vec,
    output logic [SEL_W-1:0]                youngest
);

    logic found;

    // Per-stage qualified match.
    always_comb begin
        match_vec = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            match_vec[k] = src_used & stage_mask[k] & producer_vec[k] & (dest_vec[k] == src);
        end
    end

    // Priority pick: the youngest producer wins, matches are never merged.
    always_comb begin
        youngest = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (match_vec[k] && !found) begin
                youngest = SEL_W'(k);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard detection and EXE forwarding-select unit with a shadow pipeline of
// in-flight write-backs (stage 0 = EXE ... DEPTH-1 = WB) and a global freeze
// driven by mem_ready.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cnt / fwd_cnt counters.
module pipe_hazard_fwd_unit
    import pipe_hazard_pkg::*;
#(
    parameter  int unsigned NUM_REGS   = 16,
    parameter  int unsigned DEPTH      = 3,  // must be >= 2
    parameter  int unsigned LOAD_STAGE = 2,  // 1 <= LOAD_STAGE <= DEPTH-1
    localparam int unsigned REG_W      = $clog2(NUM_REGS),
    localparam int unsigned SEL_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src_1,
    input  logic [REG_W-1:0] id_src_2,
    input  logic             id_src1_used,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             stall_front,
    output logic             freeze_all,
    output logic [SEL_W-1:0] sel_src_1,
    output logic [SEL_W-1:0] sel_src_2
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt
`endif
);

    track_entry_t [DEPTH-1:0]        entries_q;
    track_entry_t [DEPTH-1:0]        entries_d;
    track_entry_t                    id_entry;

    logic [DEPTH-1:0]                producer_vec;
    logic [DEPTH-1:0][MAX_REG_W-1:0] dest_vec;
    logic [DEPTH-1:0]                hz_mask;
    logic [DEPTH-1:0]                fw_mask;

    logic [DEPTH-1:0]                hz1_vec;
    logic [DEPTH-1:0]                hz2_vec;
    logic [DEPTH-1:0]                fw1_vec;
    logic [DEPTH-1:0]                fw2_vec;
    logic [SEL_W-1:0]                hz1_idx;
    logic [SEL_W-1:0]                hz2_idx;
    logic [SEL_W-1:0]                fw1_idx;
    logic [SEL_W-1:0]                fw2_idx;

    logic                            raw_hazard;
    logic                            load_id;

    // Pack the ID instruction into a tracker entry.
    always_comb begin
        id_entry           = TRACK_BUBBLE;
        id_entry.valid     = 1'b1;
        id_entry.wb_en     = id_wb_en;
        id_entry.is_load   = id_mem_r_en;
        id_entry.dest      = MAX_REG_W'(id_dest);
        id_entry.src_1     = MAX_REG_W'(id_src_1);
        id_entry.src_2     = MAX_REG_W'(id_src_2);
        id_entry.src1_used = id_src1_used;
        id_entry.src2_used = id_two_src;
    end

    // Per-stage producer info and the stage-eligibility masks for both queries.
    always_comb begin
        producer_vec = '0;
        dest_vec     = '0;
        hz_mask      = '0;
        fw_mask      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            producer_vec[k] = entries_q[k].valid & entries_q[k].wb_en;
            dest_vec[k]     = entries_q[k].dest;
            if (fwd_en) begin
                // Only a load that will still be too young once the consumer
                // reaches EXE forces a stall.
                hz_mask[k] = entries_q[k].is_load && (k + 1 < LOAD_STAGE);
                fw_mask[k] = (k != 0) && (!entries_q[k].is_load || k >= LOAD_STAGE);
            end else begin
                // Without forwarding, wait until the producer reaches WB
                // (write-through register file), i.e. stall for k <= DEPTH-2.
                hz_mask[k] = (k + 2 <= DEPTH);
                fw_mask[k] = 1'b0;
            end
        end
    end

    hazard_src_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_hz_src_1 (
        .producer_vec (producer_vec),
        .dest_vec     (dest_vec),
        .src          (MAX_REG_W'(id_src_1)),
        .src_used     (id_valid & id_src1_used),
        .stage_mask   (hz_mask),
        .match_vec    (hz1_vec),
        .youngest     (hz1_idx)
    );

    hazard_src_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_hz_src_2 (
        .producer_vec (producer_vec),
        .dest_vec     (dest_vec),
        .src          (MAX_REG_W'(id_src_2)),
        .src_used     (id_valid & id_two_src),
        .stage_mask   (hz_mask),
        .match_vec    (hz2_vec),
        .youngest     (hz2_idx)
    );

    hazard_src_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_fw_src_1 (
        .producer_vec (producer_vec),
        .dest_vec     (dest_vec),
        .src          (entries_q[0].src_1),
        .src_used     (entries_q[0].valid & entries_q[0].src1_used),
        .stage_mask   (fw_mask),
        .match_vec    (fw1_vec),
        .youngest     (fw1_idx)
    );

    hazard_src_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_fw_src_2 (
        .producer_vec (producer_vec),
        .dest_vec     (dest_vec),
        .src          (entries_q[0].src_2),
        .src_used     (entries_q[0].valid & entries_q[0].src2_used),
        .stage_mask   (fw_mask),
        .match_vec    (fw2_vec),
        .youngest     (fw2_idx)
    );

    assign raw_hazard = (|hz1_vec) | (|hz2_vec);

    // Outputs are forced low while rst is asserted; a branch flush beats a stall.
    assign stall_front = !rst && raw_hazard && mem_ready && !branch_taken;
    assign freeze_all  = !rst && !mem_ready;
    assign sel_src_1   = (!rst && |fw1_vec) ? fw1_idx : SEL_W'(SEL_REGFILE);
    assign sel_src_2   = (!rst && |fw2_vec) ? fw2_idx : SEL_W'(SEL_REGFILE);

    assign load_id = id_valid && !stall_front && !branch_taken;

    // Shadow pipeline advance; everything holds while memory is not ready.
    always_comb begin
        entries_d = entries_q;
        if (mem_ready) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                entries_d[k] = entries_q[k-1];
            end
            entries_d[0] = load_id ? id_entry : TRACK_BUBBLE;
        end
    end

    // Tracker state register with synchronous reset to all bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                entries_q[k] <= TRACK_BUBBLE;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Source fields of the WB entry and the hazard stage indices are not needed.
    logic unused_bits;
    assign unused_bits = ^{entries_q[DEPTH-1].src_1, entries_q[DEPTH-1].src_2,
                           entries_q[DEPTH-1].src1_used, entries_q[DEPTH-1].src2_used,
                           hz1_idx, hz2_idx};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    // Performance counters: wrap naturally, hold during a freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (!freeze_all) begin
            if (stall_front) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((sel_src_1 != SEL_W'(SEL_REGFILE)) || (sel_src_2 != SEL_W'(SEL_REGFILE))) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Directed self-checking bench for pipe_hazard_fwd_unit (default parameters:
// 16 registers, DEPTH 3, LOAD_STAGE 2).
module tb_pipe_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       fwd_en;
    logic       id_valid;
    logic [3:0] id_src_1;
    logic [3:0] id_src_2;
    logic       id_src1_used;
    logic       id_two_src;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic [3:0] id_dest;
    logic       branch_taken;
    logic       mem_ready;
    logic       stall_front;
    logic       freeze_all;
    logic [1:0] sel_src_1;
    logic [1:0] sel_src_2;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hazard_fwd_unit dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .id_src_1     (id_src_1),
        .id_src_2     (id_src_2),
        .id_src1_used (id_src1_used),
        .id_two_src   (id_two_src),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .id_dest      (id_dest),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .stall_front  (stall_front),
        .freeze_all   (freeze_all),
        .sel_src_1    (sel_src_1),
        .sel_src_2    (sel_src_2)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge, then let comb logic settle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic wb,
                          input logic ld, input logic [3:0] d);
        id_valid     = v;
        id_src_1     = s1;
        id_src1_used = u1;
        id_src_2     = s2;
        id_two_src   = u2;
        id_wb_en     = wb;
        id_mem_r_en  = ld;
        id_dest      = d;
        #1;
    endtask

    task automatic set_idle;
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic do_reset;
        rst          = 1'b1;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        fwd_en = 1'b1;
        rst    = 1'b1;
        mem_ready = 1'b0;
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 4'd1);
        tick();
        tick();
        checks++; if (freeze_all !== 1'b0) begin errors++; $display("FAIL reset_freeze_forced: got %0d want 0", freeze_all); end
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL reset_stall_forced: got %0d want 0", stall_front); end
        checks++; if (sel_src_1 !== 2'd0 || sel_src_2 !== 2'd0) begin errors++; $display("FAIL reset_sel_forced: got %0d/%0d want 0/0", sel_src_1, sel_src_2); end
        mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_stall: got %0d want 0", stall_front); end
        checks++; if (freeze_all !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_freeze: got %0d want 0", freeze_all); end
        mem_ready = 1'b0;
        #1;
        checks++; if (freeze_all !== 1'b1) begin errors++; $display("FAIL reset_freeze_follows_ready: got %0d want 1", freeze_all); end
        mem_ready = 1'b1;
        set_idle();
    endtask

    task automatic test_fwd_alu;
        do_reset();
        fwd_en = 1'b1;
        // ADD r1 <- r2, r3
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL alu_c0_stall: got %0d want 0", stall_front); end
        tick();
        // SUB r2 <- r1, r4
        set_id(1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 4'd2);
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL alu_c1_stall: got %0d want 0", stall_front); end
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL alu_c1_sel1: got %0d want 0", sel_src_1); end
        tick();
        set_idle();
        checks++; if (sel_src_1 !== 2'd1) begin errors++; $display("FAIL alu_c2_sel1: got %0d want 1", sel_src_1); end
        checks++; if (sel_src_2 !== 2'd0) begin errors++; $display("FAIL alu_c2_sel2: got %0d want 0", sel_src_2); end
        fwd_en = 1'b0;
        #1;
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL alu_fwd_off_sel1: got %0d want 0", sel_src_1); end
        fwd_en = 1'b1;
        #1;
        tick();
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL alu_c3_sel1: got %0d want 0", sel_src_1); end
    endtask

    task automatic test_load_use;
        int stalls;
        do_reset();
        fwd_en = 1'b1;
        stalls = 0;
        // LDR r3 <- [r5]
        set_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3);
        if (stall_front) stalls++;
        tick();
        // ADD r4 <- r3, r6 ; held in ID while stalled
        set_id(1'b1, 4'd3, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd4);
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL load_c1_stall: got %0d want 1", stall_front); end
        if (stall_front) stalls++;
        tick();
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL load_c2_stall: got %0d want 0", stall_front); end
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL load_c2_bubble_sel1: got %0d want 0", sel_src_1); end
        if (stall_front) stalls++;
        tick();
        set_idle();
        checks++; if (sel_src_1 !== 2'd2) begin errors++; $display("FAIL load_c3_sel1: got %0d want 2", sel_src_1); end
        checks++; if (sel_src_2 !== 2'd0) begin errors++; $display("FAIL load_c3_sel2: got %0d want 0", sel_src_2); end
        checks++; if (stalls !== 1) begin errors++; $display("FAIL load_stall_cycles: got %0d want 1", stalls); end
`ifdef HAZARD_PERF_CNT_EN
        tick();
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_stall_cnt: got %0d want 1", stall_cnt); end
        checks++; if (fwd_cnt !== 32'd1) begin errors++; $display("FAIL load_fwd_cnt: got %0d want 1", fwd_cnt); end
`endif
    endtask

    task automatic test_no_fwd;
        do_reset();
        fwd_en = 1'b0;
        // ADD r1 <- r2, r3
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        tick();
        // r1 present but unused: no hazard
        set_id(1'b1, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd5);
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL nofwd_unused_src_stall: got %0d want 0", stall_front); end
        // ORR r5 <- r1, r6
        set_id(1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd5);
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL nofwd_c1_stall: got %0d want 1", stall_front); end
        tick();
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL nofwd_c2_stall: got %0d want 1", stall_front); end
        tick();
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL nofwd_c3_stall: got %0d want 0", stall_front); end
        tick();
        set_idle();
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL nofwd_c4_sel1: got %0d want 0", sel_src_1); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        fwd_en = 1'b1;
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7);
        tick();
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7);
        tick();
        // OR r8 <- r7, r7 : two producers of r7 in flight
        set_id(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd8);
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0d want 0", stall_front); end
        tick();
        set_idle();
        checks++; if (sel_src_1 !== 2'd1) begin errors++; $display("FAIL b2b_youngest_sel1: got %0d want 1", sel_src_1); end
        checks++; if (sel_src_2 !== 2'd1) begin errors++; $display("FAIL b2b_youngest_sel2: got %0d want 1", sel_src_2); end
    endtask

    task automatic test_freeze;
        do_reset();
        fwd_en = 1'b1;
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1); // A: r1
        tick();
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2); // B: r2 <- r1
        tick();
        set_id(1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 4'd3); // C: LDR r3 <- r2, r1
        tick();
        set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4); // D: r4 <- r3
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            branch_taken = (c == 1);
            #1;
            checks++; if (freeze_all !== 1'b1) begin errors++; $display("FAIL freeze_c%0d_freeze: got %0d want 1", c, freeze_all); end
            checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL freeze_c%0d_stall: got %0d want 0", c, stall_front); end
            checks++; if (sel_src_1 !== 2'd1 || sel_src_2 !== 2'd2) begin errors++; $display("FAIL freeze_c%0d_sel: got %0d/%0d want 1/2", c, sel_src_1, sel_src_2); end
            tick();
        end
        branch_taken = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++; if (freeze_all !== 1'b0) begin errors++; $display("FAIL freeze_release_freeze: got %0d want 0", freeze_all); end
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL freeze_release_stall: got %0d want 1", stall_front); end
        checks++; if (sel_src_1 !== 2'd1 || sel_src_2 !== 2'd2) begin errors++; $display("FAIL freeze_release_sel: got %0d/%0d want 1/2", sel_src_1, sel_src_2); end
        tick();
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL freeze_post_stall: got %0d want 0", stall_front); end
        tick();
        set_idle();
        checks++; if (sel_src_1 !== 2'd2) begin errors++; $display("FAIL freeze_post_sel1: got %0d want 2", sel_src_1); end
    endtask

    task automatic test_branch_flush;
        do_reset();
        fwd_en = 1'b1;
        set_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3); // LDR r3
        tick();
        set_id(1'b1, 4'd3, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd4); // ADD r4 <- r3
        branch_taken = 1'b1;
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0d want 0", stall_front); end
        tick();
        branch_taken = 1'b0;
        set_idle();
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL flush_c2_sel1: got %0d want 0", sel_src_1); end
        tick();
        // Had ADD entered EXE, it would now forward from the load in stage 2.
        checks++; if (sel_src_1 !== 2'd0) begin errors++; $display("FAIL flush_bubble_sel1: got %0d want 0", sel_src_1); end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        fwd_en = 1'b0;
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        tick();
        set_id(1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd5);
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL rststall_pre_stall: got %0d want 1", stall_front); end
        rst = 1'b1;
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL rststall_forced: got %0d want 0", stall_front); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL rststall_after_stall: got %0d want 0", stall_front); end
        checks++; if (sel_src_1 !== 2'd0 || sel_src_2 !== 2'd0) begin errors++; $display("FAIL rststall_after_sel: got %0d/%0d want 0/0", sel_src_1, sel_src_2); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin errors++; $display("FAIL rststall_counters: got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
`endif
        set_idle();
    endtask

    initial begin
        rst          = 1'b1;
        fwd_en       = 1'b1;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        set_idle();
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_no_fwd();
        test_back_to_back();
        test_freeze();
        test_branch_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
